// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, 8-bit frames, byte handshake to a local controller
//  clk      in      system clock, at least 4x the sck rate
//  reset    in      asynchronous active-high reset
//  ss_n     in      slave select from host, active low, asynchronous
//  sck      in      serial clock from host, idles low, asynchronous
//  mosi     in      serial data from host, asynchronous
//  miso     out     serial data to host (registered)
//  miso_oe  out     miso drive enable, high for the duration of an accepted frame
//  di       in [8]  tx byte from local side
//  wr       in      strobe: load di into tx holding register
//  tx_full  out     tx holding register holds an unsent byte
//  dout     out [8] last complete received byte
//  dsr      out     dout holds an unread byte
//  rd       in      strobe: local side consumed dout
//  ovr      out     sticky: a byte completed while dsr was already high
//  busy     out     frame in progress (synced ss_n low, bit count nonzero)
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DUMMY       = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] di,
    input  logic       wr,
    output logic       tx_full,
    output logic [7:0] dout,
    output logic       dsr,
    input  logic       rd,
    output logic       ovr,
    output logic       busy
);
    localparam int S = SYNC_STAGES;
    // bit 0 is the first synchronizer flop, bit S-1 the synced value, bit S its one-cycle history
    logic [S:0]   sck_q, ss_q;
    logic [S-1:0] mosi_q, live;
    logic         armed, skip_fall;
    logic [2:0]   bit_cnt;
    logic [7:0]   tx_sh, rx_sh, tx_hold, ld;
    logic         sck_rise, sck_fall, ss_fall, ss_rise, ss_s, mosi_s;
    assign ss_s     = ss_q[S-1];
    assign mosi_s   = mosi_q[S-1];
    assign sck_rise = sck_q[S-1] & ~sck_q[S];
    assign sck_fall = ~sck_q[S-1] & sck_q[S];
    // a fall only counts once ss_n has been genuinely seen high after reset,
    // so a select held low across reset cannot start a frame
    assign ss_fall  = ~ss_s & ss_q[S] & armed;
    assign ss_rise  = ss_s & ~ss_q[S];
    assign ld       = tx_full ? tx_hold : DUMMY;
    assign busy     = ~ss_s & (bit_cnt != 3'd0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q  <= '0;
            mosi_q <= '0;
            ss_q   <= '1;
            live   <= '0;
        end else begin
            sck_q  <= {sck_q[S-1:0], sck};
            mosi_q <= {mosi_q[S-2:0], mosi};
            ss_q   <= {ss_q[S-1:0], ss_n};
            live   <= {live[S-2:0], 1'b1};
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            skip_fall <= 1'b0;
            bit_cnt   <= 3'd0;
            tx_sh     <= 8'd0;
            rx_sh     <= 8'd0;
            tx_hold   <= 8'd0;
            tx_full   <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            dout      <= 8'd0;
            dsr       <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            // live[S-1] marks that the synced ss_n now reflects the pin, not the reset value
            armed <= armed | (live[S-1] & ss_s);
            if (rd) begin
                dsr <= 1'b0;
                ovr <= 1'b0;
            end
            if (ss_rise) begin
                bit_cnt <= 3'd0;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
            end else if (ss_fall) begin
                bit_cnt   <= 3'd0;
                skip_fall <= 1'b0;
                tx_sh     <= ld;
                miso      <= ld[7];
                tx_full   <= 1'b0;
                miso_oe   <= 1'b1;
            end else if (miso_oe) begin
                if (sck_rise) begin
                    rx_sh   <= {rx_sh[6:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        dout    <= {rx_sh[6:0], mosi_s};
                        dsr     <= 1'b1;
                        if (dsr && !rd)
                            ovr <= 1'b1;
                        // next byte's MSB is already on miso, so the following fall must not shift
                        tx_sh     <= ld;
                        miso      <= ld[7];
                        tx_full   <= 1'b0;
                        skip_fall <= 1'b1;
                    end
                end else if (sck_fall) begin
                    if (skip_fall)
                        skip_fall <= 1'b0;
                    else begin
                        tx_sh <= {tx_sh[6:0], 1'b0};
                        miso  <= tx_sh[6];
                    end
                end
            end
            // a write in the same cycle as a load keeps the new byte pending
            if (wr) begin
                tx_hold <= di;
                tx_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave
module tb_spi_slave;
    logic       clk = 1'b0, reset = 1'b1, ss_n = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [7:0] di = 8'd0;
    logic       miso, miso_oe, tx_full, dsr, ovr, busy;
    logic [7:0] dout;
    int checks = 0, failures = 0;

    spi_slave dut (
        .clk(clk), .reset(reset), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .di(di), .wr(wr), .tx_full(tx_full),
        .dout(dout), .dsr(dsr), .rd(rd), .ovr(ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] di;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_do;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_wr(input logic [7:0] b);
        @(negedge clk);
        di = b;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // host side: drive n bits MSB first, sample miso just before each rising sck
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            clks(4);
            rx[i] = miso;
            sck = 1'b1;
            clks(4);
            sck = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] r, r2;
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[3] = '{1'b0, 8'h12, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{1'b1, 8'h00, 8'hAA, 8'h00, 8'hAA};
        clks(3);
        chk("reset_outputs", {miso, miso_oe, dout, dsr, ovr, tx_full, busy}, 32'd0);
        reset = 1'b0;
        clks(6);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].wr_en) begin
                pulse_wr(vecs[v].di);
                chk($sformatf("v%0d_tx_full_set", v), tx_full, 1'b1);
            end
            ss_n = 1'b0;
            clks(6);
            chk($sformatf("v%0d_oe", v), miso_oe, 1'b1);
            spi_bits(vecs[v].mosi, 8, r);
            clks(6);
            chk($sformatf("v%0d_miso", v), r, vecs[v].exp_miso);
            chk($sformatf("v%0d_do", v), dout, vecs[v].exp_do);
            chk($sformatf("v%0d_dsr", v), dsr, 1'b1);
            chk($sformatf("v%0d_ovr", v), ovr, 1'b0);
            chk($sformatf("v%0d_tx_full", v), tx_full, 1'b0);
            ss_n = 1'b1;
            clks(6);
            chk($sformatf("v%0d_oe_off", v), miso_oe, 1'b0);
            pulse_rd();
            chk($sformatf("v%0d_dsr_rd", v), dsr, 1'b0);
        end

        // back-to-back frames without rd -> overrun
        ss_n = 1'b0;
        clks(6);
        spi_bits(8'h11, 8, r);
        clks(2);
        chk("b2b_first_ovr", ovr, 1'b0);
        spi_bits(8'h22, 8, r);
        clks(6);
        chk("b2b_do", dout, 8'h22);
        chk("b2b_dsr", dsr, 1'b1);
        chk("b2b_ovr", ovr, 1'b1);
        ss_n = 1'b1;
        clks(6);
        pulse_rd();
        chk("b2b_rd", {dsr, ovr}, 2'b00);

        // second write lands mid-frame and goes out in the following byte
        pulse_wr(8'h81);
        ss_n = 1'b0;
        clks(6);
        fork
            spi_bits(8'h00, 8, r);
            begin
                clks(20);
                di = 8'h7E;
                wr = 1'b1;
                @(negedge clk);
                wr = 1'b0;
            end
        join
        chk("midwr_frame1", r, 8'h81);
        spi_bits(8'h00, 8, r2);
        clks(6);
        chk("midwr_frame2", r2, 8'h7E);
        chk("midwr_tx_full", tx_full, 1'b0);
        ss_n = 1'b1;
        clks(6);
        pulse_rd();

        // abort after 4 bits
        ss_n = 1'b0;
        clks(6);
        spi_bits(8'hF0, 4, r);
        clks(6);
        chk("abort_busy_mid", busy, 1'b1);
        ss_n = 1'b1;
        clks(6);
        chk("abort_state", {dsr, miso_oe, busy}, 3'b000);
        ss_n = 1'b0;
        clks(6);
        spi_bits(8'hC3, 8, r);
        clks(6);
        chk("abort_next_do", dout, 8'hC3);
        chk("abort_next_dsr", dsr, 1'b1);
        ss_n = 1'b1;
        clks(6);
        pulse_rd();

        // reset mid-frame with ss_n held low
        pulse_wr(8'h55);
        ss_n = 1'b0;
        clks(6);
        spi_bits(8'hAA, 3, r);
        #2 reset = 1'b1;
        clks(2);
        chk("rst_mid_outputs", {miso, miso_oe, dout, dsr, ovr, tx_full, busy}, 32'd0);
        reset = 1'b0;
        clks(6);
        spi_bits(8'hFF, 8, r);
        clks(6);
        chk("rst_no_frame", {dsr, miso_oe, dout}, 10'd0);
        ss_n = 1'b1;
        clks(6);
        ss_n = 1'b0;
        clks(6);
        spi_bits(8'h5A, 8, r);
        clks(6);
        chk("rst_new_frame_do", dout, 8'h5A);
        chk("rst_new_frame_miso", r, 8'hFF);
        ss_n = 1'b1;
        clks(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
